// File: rtl/mul_add_pkg.sv
// Shared constants and types for the mul_add pipeline and its egress stage.
package mul_add_pkg;
  localparam int MUL_ADD_LATENCY = 3;
  localparam int MUL_ADD_WIDTH   = 32;

  typedef logic [MUL_ADD_WIDTH-1:0] mul_add_word_t;
endpackage

// File: rtl/mul_add_egress_fifo.sv
// Result FIFO for the egress stage: storage, wrap-at-DEPTH pointers and occupancy.
module mul_add_egress_fifo
  import mul_add_pkg::*;
#(
  parameter int WIDTH = MUL_ADD_WIDTH,
  parameter int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) return '0;
    return ptr + PTR_W'(1);
  endfunction

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign do_pop = pop & ~empty;
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mul_add_egress.sv
// Egress stage for mul_add: tags accepted issues through the fixed-latency pipe,
// captures matching results into a FIFO and hands out issue credits.
module mul_add_egress
  import mul_add_pkg::*;
#(
  parameter int WIDTH   = MUL_ADD_WIDTH,
  parameter int LATENCY = MUL_ADD_LATENCY,
  parameter int DEPTH   = 8,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int IN_W   = $clog2(LATENCY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic [IN_W-1:0]  inflight
);

  // Handshakes: an issue transfers on an edge where issue_valid & issue_ready;
  // a result transfers on an edge where out_valid & out_ready. issue_ready and
  // out_valid depend on registered state only.

  localparam int SUM_W = CNT_W + IN_W;

  logic [LATENCY-1:0] tag;
  logic               accept;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [SUM_W-1:0]   occupancy;

  assign accept    = issue_valid & issue_ready;
  assign push      = tag[LATENCY-1];
  assign pop       = out_valid & out_ready;
  assign out_valid = ~empty;

  // Credits cover both captured results and results still inside mul_add.
  assign occupancy   = SUM_W'(count) + SUM_W'(inflight);
  assign issue_ready = (occupancy < SUM_W'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag      <= '0;
      inflight <= '0;
    end else begin
      tag[0] <= accept;
      for (int i = 1; i < LATENCY; i++) tag[i] <= tag[i-1];
      case ({accept, push})
        2'b10:   inflight <= inflight + IN_W'(1);
        2'b01:   inflight <= inflight - IN_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  mul_add_egress_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (result),
    .pop   (pop),
    .rdata (out_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  push_while_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop));

endmodule

// File: tb/tb_mul_add_egress.sv
// Directed bench for mul_add_egress with a behavioural 3-stage mul_add beside it.
module tb_mul_add_egress;
  import mul_add_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_valid;
  logic          issue_ready;
  logic          out_valid;
  logic          out_ready;
  mul_add_word_t result;
  mul_add_word_t out_data;
  logic [3:0]    count;
  logic [1:0]    inflight;

  mul_add_word_t x, y, z;
  mul_add_word_t s0, s1, s2;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / mul_add model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    s0 <= x * y + z;
    s1 <= s0;
    s2 <= s1;
  end
  assign result = s2;

  mul_add_egress dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .result      (result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .inflight    (inflight)
  );

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    x = 32'hdead_beef;
    y = 32'h0000_1234;
    z = 32'h0bad_f00d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid actual=%b expected=0", out_valid); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready actual=%b expected=1", issue_ready); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count actual=%0d expected=0", count); end
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL reset_inflight actual=%0d expected=0", inflight); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    x = 3; y = 5; z = 7;
    issue_valid = 1'b1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL single_ready actual=%b expected=1", issue_ready); end
    tick();
    idle_inputs();
    checks++; if (inflight !== 2'd1) begin errors++; $display("FAIL single_inflight1 actual=%0d expected=1", inflight); end
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid actual=%b expected=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid actual=%b expected=1", out_valid); end
    checks++; if (out_data !== 32'd22) begin errors++; $display("FAIL single_data actual=%0d expected=22", out_data); end
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL single_inflight0 actual=%0d expected=0", inflight); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count1 actual=%0d expected=1", count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_count0 actual=%0d expected=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after_pop actual=%b expected=0", out_valid); end
  endtask

  task automatic test_async_reset();
    x = 2; y = 2; z = 2;
    issue_valid = 1'b1;
    tick();
    idle_inputs();
    repeat (3) tick();
    x = 9; y = 9; z = 9;
    issue_valid = 1'b1;
    tick();
    idle_inputs();
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL async_pre_count actual=%0d expected=1", count); end
    checks++; if (inflight !== 2'd1) begin errors++; $display("FAIL async_pre_inflight actual=%0d expected=1", inflight); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid actual=%b expected=0", out_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL async_count actual=%0d expected=0", count); end
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL async_inflight actual=%0d expected=0", inflight); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL async_issue_ready actual=%b expected=1", issue_ready); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    int sent = 0;
    int got = 0;
    logic [31:0] expv;
    exp_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (got > 0 && got < 16) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_gap cycle=%0d actual=%b expected=1", c, out_valid); end
      end
      if (out_valid === 1'b1) begin
        expv = (exp_q.size() != 0) ? exp_q[0] : 32'hffff_ffff;
        checks++; if (out_data !== expv) begin errors++; $display("FAIL stream_data idx=%0d actual=%0d expected=%0d", got, out_data, expv); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (sent < 16) begin
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL stream_ready idx=%0d actual=%b expected=1", sent, issue_ready); end
        issue_valid = 1'b1;
        x = 32'(sent); y = 2; z = 1;
        exp_q.push_back(32'(2 * sent + 1));
        sent++;
      end else begin
        idle_inputs();
      end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (got != 16) begin errors++; $display("FAIL stream_total actual=%0d expected=16", got); end
  endtask

  task automatic test_backpressure();
    int popped = 0;
    logic [31:0] expv;
    exp_q.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 14; c++) begin
      checks++; if (issue_ready !== (c < 8)) begin errors++; $display("FAIL bp_ready cycle=%0d actual=%b expected=%b", c, issue_ready, (c < 8)); end
      if (c < 8) exp_q.push_back(32'((c + 10) * 3 + c));
      issue_valid = 1'b1;
      x = 32'(c + 10); y = 3; z = 32'(c);
      tick();
    end
    idle_inputs();
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL bp_full_count actual=%0d expected=8", count); end
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL bp_full_inflight actual=%0d expected=0", inflight); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready actual=%b expected=0", issue_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) begin
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL bp_credit_return actual=%b expected=1", issue_ready); end
      end
      if (out_valid === 1'b1) begin
        expv = (exp_q.size() != 0) ? exp_q[0] : 32'hffff_ffff;
        checks++; if (out_data !== expv) begin errors++; $display("FAIL bp_data idx=%0d actual=%0d expected=%0d", popped, out_data, expv); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        popped++;
      end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (popped != 8) begin errors++; $display("FAIL bp_drained actual=%0d expected=8", popped); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL bp_count_end actual=%0d expected=0", count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    issue_valid = 1'b1;
    x = 1; y = 1; z = 1;
    tick();
    x = 2;
    tick();
    idle_inputs();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL mid_inflight actual=%0d expected=0", inflight); end
    for (int c = 0; c < 10; c++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid cycle=%0d actual=%b expected=0", c, out_valid); end
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL mid_count cycle=%0d actual=%0d expected=0", c, count); end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_simul_push_pop();
    out_ready = 1'b0;
    issue_valid = 1'b1;
    x = 4; y = 4; z = 4;
    tick();
    x = 6; y = 7; z = 8;
    tick();
    idle_inputs();
    tick();
    tick();
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL simul_pre_count actual=%0d expected=1", count); end
    checks++; if (out_data !== 32'd20) begin errors++; $display("FAIL simul_pre_data actual=%0d expected=20", out_data); end
    checks++; if (inflight !== 2'd1) begin errors++; $display("FAIL simul_pre_inflight actual=%0d expected=1", inflight); end
    out_ready = 1'b1;
    tick();
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL simul_count actual=%0d expected=1", count); end
    checks++; if (out_data !== 32'd50) begin errors++; $display("FAIL simul_data actual=%0d expected=50", out_data); end
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL simul_inflight actual=%0d expected=0", inflight); end
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL simul_count_end actual=%0d expected=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL simul_valid_end actual=%b expected=0", out_valid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_async_reset();
    test_streaming();
    test_backpressure();
    test_reset_mid();
    test_simul_push_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
